// File: rtl/hfc_pkg.sv
// Shared types and constants for the hazard/forwarding controller: scoreboard
// entry layout, forward-select codes and Tnew/Tuse reference values.
package hfc_pkg;

    localparam int HFC_REG_AW = 5;
    localparam int HFC_TW     = 2;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_M  = 2'b01;
    localparam fwd_sel_t FWD_W  = 2'b10;

    localparam logic [HFC_TW-1:0] TNEW_ALU  = 2'd2;
    localparam logic [HFC_TW-1:0] TNEW_LOAD = 2'd3;
    localparam logic [HFC_TW-1:0] TUSE_D    = 2'd0;
    localparam logic [HFC_TW-1:0] TUSE_E    = 2'd1;

    typedef struct packed {
        logic                  valid;
        logic [HFC_REG_AW-1:0] addr;
        logic [HFC_TW-1:0]     tnew;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    typedef enum logic [1:0] {
        HIT_NONE = 2'd0,
        HIT_E    = 2'd1,
        HIT_M    = 2'd2,
        HIT_W    = 2'd3
    } hit_stage_e;

    // Tnew only ever counts down towards "result available"; it must not wrap.
    function automatic logic [HFC_TW-1:0] tnew_dec(input logic [HFC_TW-1:0] t);
        return (t == '0) ? '0 : t - HFC_TW'(1);
    endfunction

    function automatic fwd_sel_t sel_from_hit(input hit_stage_e hit,
                                              input logic [HFC_TW-1:0] rem);
        fwd_sel_t sel;
        sel = FWD_RF;
        if (hit == HIT_M && rem == '0) begin
            sel = FWD_M;
        end else if (hit == HIT_W) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hfc_match.sv
// Youngest-first producer search for one source operand over the E/M/W
// scoreboard; reports the hit stage and the producer's remaining Tnew.
module hfc_match
    import hfc_pkg::*;
(
    input  logic [HFC_REG_AW-1:0] src_addr_i,
    input  logic                  src_used_i,
    input  sb_entry_t             sb_e_i,
    input  sb_entry_t             sb_m_i,
    input  sb_entry_t             sb_w_i,
    output hit_stage_e            hit_o,
    output logic [HFC_TW-1:0]     tnew_o
);

    logic live;
    assign live = src_used_i && (src_addr_i != '0);

    // Every stored tnew is one higher than what remains for the reader, so
    // the same saturating decrement applies at all three stages.
    // NOTE: every output gets a default before the priority chain, so no
    // path through the block can leave a latch behind.
    always_comb begin
        hit_o  = HIT_NONE;
        tnew_o = '0;
        if (live) begin
            if (sb_e_i.valid && sb_e_i.addr == src_addr_i) begin
                hit_o  = HIT_E;
                tnew_o = tnew_dec(sb_e_i.tnew);
            end else if (sb_m_i.valid && sb_m_i.addr == src_addr_i) begin
                hit_o  = HIT_M;
                tnew_o = tnew_dec(sb_m_i.tnew);
            end else if (sb_w_i.valid && sb_w_i.addr == src_addr_i) begin
                hit_o  = HIT_W;
                tnew_o = tnew_dec(sb_w_i.tnew);
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// D-stage stall and forward-select generation for the 5-stage pipeline,
// with an E/M/W write scoreboard and a multicycle mult/div busy tracker.
module hazard_fwd_ctrl
    import hfc_pkg::*;
#(
    parameter int N_SRC    = 2,
    parameter int REG_AW   = HFC_REG_AW,
    parameter int TW       = HFC_TW,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_valid,
    input  logic [N_SRC*REG_AW-1:0] d_src_addr,
    input  logic [N_SRC-1:0]      d_src_used,
    input  logic [N_SRC*TW-1:0]   d_src_tuse,
    input  logic [REG_AW-1:0]     d_dst_addr,
    input  logic [TW-1:0]         d_tnew,
    input  logic                  d_md_start,
    input  logic                  d_md_is_div,
    input  logic                  d_md_use,
    output logic                  stall,
    output logic [N_SRC*2-1:0]    fwd_d_sel,
    output logic [N_SRC*2-1:0]    fwd_e_sel,
    output logic                  md_busy
);

    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CNT_W  = $clog2(MD_MAX + 1);

    sb_entry_t sb_e_q, sb_m_q, sb_w_q;
    sb_entry_t sb_e_d, sb_m_d, sb_w_d;

    logic             e_md_start_q, e_md_start_d;
    logic             e_md_div_q, e_md_div_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic [N_SRC*2-1:0] fwd_e_sel_q, fwd_e_sel_d;
    logic [N_SRC-1:0]   src_stall;
    logic               md_stall;

    // D-side search sees the current scoreboard; E-side search looks at the
    // M/W contents of the next cycle, when the instruction sits in E.
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        hit_stage_e    d_hit, e_hit;
        logic [TW-1:0] d_rem, e_rem;
        logic          e_used;

        assign e_used = d_valid & ~stall & d_src_used[i];

        hfc_match u_d_match (
            .src_addr_i (d_src_addr[i*REG_AW +: REG_AW]),
            .src_used_i (d_src_used[i]),
            .sb_e_i     (sb_e_q),
            .sb_m_i     (sb_m_q),
            .sb_w_i     (sb_w_q),
            .hit_o      (d_hit),
            .tnew_o     (d_rem)
        );

        hfc_match u_e_match (
            .src_addr_i (d_src_addr[i*REG_AW +: REG_AW]),
            .src_used_i (e_used),
            .sb_e_i     (SB_EMPTY),
            .sb_m_i     (sb_m_d),
            .sb_w_i     (sb_w_d),
            .hit_o      (e_hit),
            .tnew_o     (e_rem)
        );

        assign src_stall[i] = (d_hit != HIT_NONE) &&
                              (d_rem > d_src_tuse[i*TW +: TW]);
        assign fwd_d_sel[i*2 +: 2]   = sel_from_hit(d_hit, d_rem);
        assign fwd_e_sel_d[i*2 +: 2] = sel_from_hit(e_hit, e_rem);
    end

    // An MDU start still in E has not loaded the counter yet, so it counts as busy.
    assign md_stall = d_md_use & (md_busy | e_md_start_q);
    assign stall    = d_valid & (|src_stall | md_stall);
    assign md_busy  = (md_cnt_q != '0);

    always_comb begin
        sb_m_d = '{valid: sb_e_q.valid, addr: sb_e_q.addr, tnew: tnew_dec(sb_e_q.tnew)};
        sb_w_d = '{valid: sb_m_q.valid, addr: sb_m_q.addr, tnew: tnew_dec(sb_m_q.tnew)};

        sb_e_d       = SB_EMPTY;
        e_md_start_d = 1'b0;
        e_md_div_d   = 1'b0;
        if (!stall) begin
            sb_e_d = '{valid: d_valid && (d_dst_addr != '0),
                       addr:  d_dst_addr,
                       tnew:  d_tnew};
            e_md_start_d = d_valid & d_md_start;
            e_md_div_d   = d_valid & d_md_start & d_md_is_div;
        end
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_md_start_q) begin
            md_cnt_d = e_md_div_q ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_e_q       <= SB_EMPTY;
            sb_m_q       <= SB_EMPTY;
            sb_w_q       <= SB_EMPTY;
            e_md_start_q <= 1'b0;
            e_md_div_q   <= 1'b0;
            md_cnt_q     <= '0;
            fwd_e_sel_q  <= '0;
        end else begin
            sb_e_q       <= sb_e_d;
            sb_m_q       <= sb_m_d;
            sb_w_q       <= sb_w_d;
            e_md_start_q <= e_md_start_d;
            e_md_div_q   <= e_md_div_d;
            md_cnt_q     <= md_cnt_d;
            fwd_e_sel_q  <= fwd_e_sel_d;
        end
    end

    assign fwd_e_sel = fwd_e_sel_q;

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Tracks in-flight register writes in a per-stage scoreboard (E, M, W).
- Generates the D-stage stall and the forwarding-mux selects for the D-stage (compare/branch) and E-stage (ALU) operands.
- Tracks a multicycle mult/div unit and stalls HI/LO consumers while it is busy.
- Replaces the hand-decoded forward selects used today; the data muxes stay outside and consume the select codes.

Parameters:
N_SRC, 2, number of source operands per instruction.
REG_AW, 5, register address width.
TW, 2, width of Tnew/Tuse fields.
MULT_LAT, 5, mult busy cycles.
DIV_LAT, 10, div busy cycles.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
d_valid  in  1  D holds a real instruction.
d_src_addr  in  N_SRC*REG_AW  source register addresses, source i at [i*REG_AW +: REG_AW].
d_src_used  in  N_SRC  source i is read.
d_src_tuse  in  N_SRC*TW  cycles from D until source i is needed (0 = in D, 1 = in E).
d_dst_addr  in  REG_AW  destination register; 0 = none.
d_tnew  in  TW  cycles from D until the result exists in a pipeline register (ALU = 2 → M, load = 3 → W, jal = 2 → M via PC8).
d_md_start  in  1  D instruction is mult/div.
d_md_is_div  in  1  the started op is div.
d_md_use  in  1  D instruction reads/writes HI/LO or starts the MDU.
stall  out  1  freeze PC and the F/D register; bubble into E.
fwd_d_sel  out  N_SRC*2  D-operand select.
fwd_e_sel  out  N_SRC*2  E-operand select (registered).
md_busy  out  1  MDU counter non-zero.

Behaviour:
Select encoding (both select outputs):
- 00 = register file / pipeline register value.
- 01 = M-stage result.
- 10 = W-stage result.
- 11 = reserved, never driven.

Scoreboard:
- Entries SB_E, SB_M, SB_W, each {valid, addr, tnew}.
- Every cycle: SB_W <= SB_M with tnew-1, saturating at 0; SB_M <= SB_E with tnew-1, saturating at 0.
- SB_E <= D entry {d_valid & d_dst_addr!=0, d_dst_addr, d_tnew} when stall=0; otherwise SB_E <= bubble (valid=0).

Stall (combinational):
- For each used source with addr!=0, take the youngest valid matching entry, searching E then M then W.
- Stall if that entry's tnew > source tuse. Define tnew as seen from D: SB_E tnew-1, SB_M tnew-2, SB_W tnew-3, each saturating at 0.
- MDU stall: d_md_use & (md_busy | SB_E holds an md start).
- stall is ANDed with d_valid.

fwd_d_sel (combinational): for the youngest match per source:
- M entry with remaining tnew 0 → 01.
- W entry → 10.
- Otherwise → 00.
- Address 0 never forwards.

fwd_e_sel (registered):
- On each non-stall cycle, D source addresses and used bits are captured into E-side registers. On stall they are cleared (bubble).
- Selects are computed from the SB_M/SB_W contents of the following cycle with the same youngest-first rule, and registered.
- Effective latency: the select is valid in the cycle the instruction occupies E.

MDU:
- When SB_E holds an md start, the counter loads MULT_LAT or DIV_LAT, then decrements to 0.
- md_busy = counter != 0.
- A new start while busy cannot occur, because it is stalled.

Reset:
- All scoreboard entries invalid, E-side registers cleared, counter 0.
- stall=0, fwd_d_sel=0, fwd_e_sel=0, md_busy=0.
- Reset mid-MDU-operation aborts the count.

Boundary cases:
- Simultaneous E/M/W matches: the youngest wins.
- Tnew saturates at 0; it never wraps.
- A stall cycle never changes the M/W advance.

Decomposition:
- Package hfc_pkg: select constants FWD_RF/FWD_M/FWD_W, the sb_entry_t typedef {valid, addr, tnew}, and Tnew/Tuse constants TNEW_ALU=2, TNEW_LOAD=3, TUSE_D=0, TUSE_E=1.
- One sub-module, hfc_match, instantiated per source: youngest-match search returning hit stage and remaining tnew.

Test Plan:
- addu $3 (tnew 2) then beq $3 (tuse 0) → stall=1 for 1 cycle; next cycle fwd_d_sel=01.
- lw $5 (tnew 3) then addu uses $5 (tuse 1) → 1 stall cycle; in E, fwd_e_sel=10.
- addu $4 in M and ori $4 in E, consumer in E → fwd_e_sel=01 (younger M result, not W).
- Writes to $0 followed by a $0 read → stall=0, selects 00.
- mult (MULT_LAT=5) then mflo → md_busy high for 5 cycles; stall held through the E-cycle plus busy, then released.
- reset asserted during div busy count 3 → next cycle md_busy=0, stall=0, all selects 00.
